// File: rtl/avalon_wr_pkg.sv
// Shared widths and state type for the Avalon-MM write master.
package avalon_wr_pkg;

    localparam int AVL_ADDR_W = 17;
    localparam int AVL_DATA_W = 521;

    typedef enum logic {
        IDLE,
        REQ
    } wr_state_t;

endpackage

// File: rtl/avalon_write_master.sv
// Drains a show-ahead FIFO into sequential Avalon-MM writes, one beat per cycle,
// with a rebasing address that can be re-targeted while a beat is in flight.
module avalon_write_master
    import avalon_wr_pkg::*;
(
    input  logic                  clk,
    input  logic                  SoftReset,
    input  logic                  setWr_addr_valid,
    input  logic [AVL_ADDR_W-1:0] setWr_addr_write,
    input  logic                  msg_in_empty,
    input  logic [AVL_DATA_W-1:0] msg_in_data,
    output logic                  msg_in_pop,
    output logic                  topA_write,
    output logic [AVL_ADDR_W-1:0] topA_address,
    output logic [AVL_DATA_W-1:0] topA_writedata,
    input  logic                  topA_waitrequest,
    output logic                  busy,
    output logic [AVL_ADDR_W-1:0] wr_count
);

    wr_state_t             state_q, state_n;
    logic [AVL_ADDR_W-1:0] addr_q, addr_n;
    logic [AVL_DATA_W-1:0] data_q, data_n;
    logic                  pend_v_q, pend_v_n;
    logic [AVL_ADDR_W-1:0] pend_addr_q, pend_addr_n;
    logic [AVL_ADDR_W-1:0] count_q, count_n;
    logic                  pop;

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_n;
            addr_q      <= addr_n;
            data_q      <= data_n;
            pend_v_q    <= pend_v_n;
            pend_addr_q <= pend_addr_n;
            count_q     <= count_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        addr_n      = addr_q;
        data_n      = data_q;
        pend_v_n    = pend_v_q;
        pend_addr_n = pend_addr_q;
        count_n     = count_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (setWr_addr_valid) begin
                    addr_n = setWr_addr_write;
                end else if (!msg_in_empty) begin
                    pop    = 1'b1;
                    data_n = msg_in_data;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (!topA_waitrequest) begin
                    count_n  = count_q + 1'b1;
                    pend_v_n = 1'b0;
                    // A same-cycle rebase outranks an older pending one.
                    if (setWr_addr_valid)
                        addr_n = setWr_addr_write;
                    else if (pend_v_q)
                        addr_n = pend_addr_q;
                    else
                        addr_n = addr_q + 1'b1;
                    if (!msg_in_empty) begin
                        pop    = 1'b1;
                        data_n = msg_in_data;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (setWr_addr_valid) begin
                    pend_v_n    = 1'b1;
                    pend_addr_n = setWr_addr_write;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pop is combinational, so it must be masked while reset holds the FSM in IDLE.
    assign msg_in_pop     = pop & ~SoftReset;
    assign topA_write     = (state_q == REQ);
    assign busy           = (state_q == REQ);
    assign topA_address   = addr_q;
    assign topA_writedata = data_q;
    assign wr_count       = count_q;

endmodule

// File: tb/tb_avalon_write_master.sv
// Directed bench for avalon_write_master with a transaction-level reference model.
module tb_avalon_write_master;

    logic         clk = 1'b0;
    logic         SoftReset = 1'b1;
    logic         setWr_addr_valid = 1'b0;
    logic [16:0]  setWr_addr_write = '0;
    logic         msg_in_empty = 1'b1;
    logic [520:0] msg_in_data = '0;
    logic         msg_in_pop;
    logic         topA_write;
    logic [16:0]  topA_address;
    logic [520:0] topA_writedata;
    logic         topA_waitrequest = 1'b0;
    logic         busy;
    logic [16:0]  wr_count;

    avalon_write_master dut (
        .clk              (clk),
        .SoftReset        (SoftReset),
        .setWr_addr_valid (setWr_addr_valid),
        .setWr_addr_write (setWr_addr_write),
        .msg_in_empty     (msg_in_empty),
        .msg_in_data      (msg_in_data),
        .msg_in_pop       (msg_in_pop),
        .topA_write       (topA_write),
        .topA_address     (topA_address),
        .topA_writedata   (topA_writedata),
        .topA_waitrequest (topA_waitrequest),
        .busy             (busy),
        .wr_count         (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0]  addr;
        logic [520:0] data;
        int           cyc;
    } beat_t;

    int           nerr = 0;
    int           nchk = 0;
    int           cyc = 0;
    int           hi_cnt = 0;
    int           npops = 0;
    logic [520:0] fifo[$];
    beat_t        log_q[$];

    // Reference model: current beat (if any), its target, a pending rebase, beat count.
    logic         m_busy = 0, m_busy_n = 0;
    logic [16:0]  m_addr = '0, m_addr_n = '0;
    logic [520:0] m_word = '0, m_word_n = '0;
    logic         m_pv = 0, m_pv_n = 0;
    logic [16:0]  m_pa = '0, m_pa_n = '0;
    logic [16:0]  m_count = '0, m_count_n = '0;

    task automatic chk(input string name, input logic [520:0] got, input logic [520:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [520:0] mk(input int n);
        logic [31:0] w;
        w = 32'hCAFE_0000 | n;
        return {9'(n), {16{w}}};
    endfunction

    always @(negedge clk) begin
        logic accept, e_pop;
        cyc++;
        if (SoftReset) begin
            chk("rst_write", topA_write, 0);
            chk("rst_pop", msg_in_pop, 0);
            chk("rst_busy", busy, 0);
            chk("rst_addr", topA_address, 0);
            chk("rst_data", topA_writedata, 0);
            chk("rst_count", wr_count, 0);
        end else begin
            accept = m_busy && !topA_waitrequest;
            e_pop  = m_busy ? (accept && !msg_in_empty) : (!msg_in_empty && !setWr_addr_valid);
            chk("write", topA_write, m_busy);
            chk("busy", busy, m_busy);
            chk("pop", msg_in_pop, e_pop);
            chk("count", wr_count, m_count);
            if (m_busy) begin
                chk("addr", topA_address, m_addr);
                chk("data", topA_writedata, m_word);
            end
            if (topA_write) hi_cnt++;
            if (topA_write && !topA_waitrequest)
                log_q.push_back('{topA_address, topA_writedata, cyc});
            m_busy_n = m_busy; m_addr_n = m_addr; m_word_n = m_word;
            m_pv_n = m_pv; m_pa_n = m_pa; m_count_n = m_count;
            if (!m_busy) begin
                if (setWr_addr_valid) m_addr_n = setWr_addr_write;
                if (e_pop) begin m_busy_n = 1; m_word_n = msg_in_data; end
            end else if (accept) begin
                m_count_n = m_count + 1;
                m_addr_n  = setWr_addr_valid ? setWr_addr_write :
                            m_pv ? m_pa : 17'((m_addr + 1) % 131072);
                m_pv_n    = 0;
                if (!msg_in_empty) m_word_n = msg_in_data;
                else m_busy_n = 0;
            end else if (setWr_addr_valid) begin
                m_pv_n = 1; m_pa_n = setWr_addr_write;
            end
        end
    end

    always @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            m_busy = 0; m_addr = '0; m_word = '0; m_pv = 0; m_pa = '0; m_count = '0;
        end else begin
            m_busy = m_busy_n; m_addr = m_addr_n; m_word = m_word_n;
            m_pv = m_pv_n; m_pa = m_pa_n; m_count = m_count_n;
        end
    end

    task automatic refresh();
        msg_in_empty = (fifo.size() == 0);
        msg_in_data  = (fifo.size() == 0) ? '0 : fifo[0];
    endtask

    task automatic tick();
        logic pop_s, pop_ok;
        @(negedge clk);
        pop_s = msg_in_pop;
        @(posedge clk);
        pop_ok = pop_s && !SoftReset;
        #1;
        if (pop_ok) begin
            void'(fifo.pop_front());
            npops++;
        end
        refresh();
    endtask

    task automatic set_base(input logic [16:0] a);
        setWr_addr_valid = 1; setWr_addr_write = a;
        tick();
        setWr_addr_valid = 0;
    endtask

    task automatic wait_write();
        int n = 0;
        while (!topA_write && n < 50) begin tick(); n++; end
        if (!topA_write) begin
            nchk++; nerr++;
            $display("FAIL wait_write: got timeout expected topA_write=1");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((topA_write || fifo.size() != 0) && n < 200) begin tick(); n++; end
        if (topA_write || fifo.size() != 0) begin
            nchk++; nerr++;
            $display("FAIL wait_idle: got timeout expected idle");
        end
        tick(); tick();
    endtask

    initial begin
        int lb, pb;
        refresh();
        repeat (3) tick();
        SoftReset = 0;
        tick();

        // Three back-to-back beats from base 0x100.
        set_base(17'h00100);
        lb = log_q.size(); pb = npops;
        fifo.push_back(mk(1)); fifo.push_back(mk(2)); fifo.push_back(mk(3)); refresh();
        wait_idle();
        chk("s1_beats", log_q.size() - lb, 3);
        if (log_q.size() >= lb + 3) begin
            chk("s1_a0", log_q[lb].addr, 17'h00100);
            chk("s1_a1", log_q[lb+1].addr, 17'h00101);
            chk("s1_a2", log_q[lb+2].addr, 17'h00102);
            chk("s1_d0", log_q[lb].data, mk(1));
            chk("s1_d2", log_q[lb+2].data, mk(3));
            chk("s1_consec", log_q[lb+2].cyc - log_q[lb].cyc, 2);
        end
        chk("s1_pops", npops - pb, 3);
        chk("s1_count", wr_count, 3);
        chk("s1_busy", busy, 0);

        // Single beat stalled for five cycles.
        set_base(17'h00010);
        lb = log_q.size(); pb = npops;
        topA_waitrequest = 1;
        fifo.push_back(mk(4)); refresh();
        wait_write();
        hi_cnt = 0;
        repeat (5) tick();
        topA_waitrequest = 0;
        wait_idle();
        chk("s2_hi_cycles", hi_cnt, 6);
        chk("s2_beats", log_q.size() - lb, 1);
        if (log_q.size() > lb) begin
            chk("s2_addr", log_q[lb].addr, 17'h00010);
            chk("s2_data", log_q[lb].data, mk(4));
        end
        chk("s2_pops", npops - pb, 1);
        chk("s2_count", wr_count, 4);

        // Address wrap at the top of the space.
        set_base(17'h1FFFF);
        lb = log_q.size();
        fifo.push_back(mk(5)); fifo.push_back(mk(6)); refresh();
        wait_idle();
        chk("s3_beats", log_q.size() - lb, 2);
        if (log_q.size() >= lb + 2) begin
            chk("s3_a0", log_q[lb].addr, 17'h1FFFF);
            chk("s3_a1", log_q[lb+1].addr, 17'h00000);
        end
        chk("s3_count", wr_count, 6);

        // Rebase while the first beat is stalled.
        set_base(17'h00020);
        lb = log_q.size();
        topA_waitrequest = 1;
        fifo.push_back(mk(7)); fifo.push_back(mk(8)); fifo.push_back(mk(9)); refresh();
        wait_write();
        tick();
        set_base(17'h00400);
        tick();
        topA_waitrequest = 0;
        wait_idle();
        chk("s4_beats", log_q.size() - lb, 3);
        if (log_q.size() >= lb + 3) begin
            chk("s4_a0", log_q[lb].addr, 17'h00020);
            chk("s4_a1", log_q[lb+1].addr, 17'h00400);
            chk("s4_a2", log_q[lb+2].addr, 17'h00401);
            chk("s4_d1", log_q[lb+1].data, mk(8));
        end
        chk("s4_count", wr_count, 9);

        // Asynchronous reset in the middle of a stall.
        lb = log_q.size();
        topA_waitrequest = 1;
        fifo.push_back(mk(10)); fifo.push_back(mk(11)); refresh();
        wait_write();
        tick();
        @(negedge clk);
        #2 SoftReset = 1;
        #1;
        chk("s5_write_drop", topA_write, 0);
        chk("s5_count_clr", wr_count, 0);
        chk("s5_busy", busy, 0);
        tick(); tick();
        chk("s5_fifo_kept", fifo.size(), 1);
        SoftReset = 0;
        topA_waitrequest = 0;
        wait_idle();
        chk("s5_beats", log_q.size() - lb, 1);
        if (log_q.size() > lb) begin
            chk("s5_addr", log_q[lb].addr, 17'h00000);
            chk("s5_data", log_q[lb].data, mk(11));
        end
        chk("s5_count", wr_count, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/avalon_write_master.md
AVALON_WRITE_MASTER -- requirements
Module: avalon_write_master

Interface
REQ-001 SHALL: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL: SoftReset  input  1  reset, asynchronous and active-high.
REQ-003 SHALL: setWr_addr_valid  input  1  one-cycle pulse loading a new base write address.
REQ-004 SHALL: setWr_addr_write  input  17  base address, sampled when setWr_addr_valid=1.
REQ-005 SHALL: msg_in_empty  input  1  show-ahead source FIFO empty flag.
REQ-006 SHALL: msg_in_data  input  521  source FIFO head word, valid whenever msg_in_empty=0.
REQ-007 SHALL: msg_in_pop  output  1  pops the FIFO head this cycle.
REQ-008 SHALL: topA_write  output  1  Avalon-MM write request.
REQ-009 SHALL: topA_address  output  17  Avalon-MM word address.
REQ-010 SHALL: topA_writedata  output  521  Avalon-MM write data.
REQ-011 SHALL: topA_waitrequest  input  1  slave stall; a beat is accepted when topA_write=1 and topA_waitrequest=0.
REQ-012 SHALL: busy  output  1  high in state REQ.
REQ-013 SHALL: wr_count  output  17  accepted beats since reset, wrapping modulo 2^17.

Function
REQ-014 SHALL: FSM states are IDLE and REQ; topA_write=1 exactly when state=REQ.
REQ-015 SHALL: in IDLE, msg_in_pop=1 when msg_in_empty=0 and setWr_addr_valid=0; msg_in_data is then registered into the write-data register, and the state moves to REQ on the next cycle.
REQ-016 SHALL: in IDLE, setWr_addr_valid=1 loads the address register and suppresses msg_in_pop that cycle.
REQ-017 SHALL: in REQ with topA_waitrequest=1, hold topA_address and topA_writedata stable, keep msg_in_pop=0, and hold wr_count.
REQ-018 SHALL: in REQ with topA_waitrequest=0 (accept), increment wr_count and update the address register to the next address per REQ-019/REQ-020.
REQ-019 SHALL: the next address after an accept is the pending address if one is held, otherwise address+1, wrapping from 0x1FFFF to 0x00000.
REQ-020 SHALL: setWr_addr_valid=1 in REQ latches setWr_addr_write into a single pending register; a later pulse overwrites it; the pending register is consumed and cleared on the next accept.
REQ-021 SHALL: on an accept with setWr_addr_valid=1 in the same cycle, use the new setWr_addr_write value as the next address.
REQ-022 SHALL: on accept with msg_in_empty=0, assert msg_in_pop combinationally in the same cycle, load the new word, and stay in REQ, giving one beat per cycle throughput.
REQ-023 SHALL: on accept with msg_in_empty=1, return to IDLE.
REQ-024 SHALL: latency from msg_in_empty falling (in IDLE) to topA_write rising is exactly 1 cycle.
REQ-025 SHALL: never pop while topA_waitrequest=1; no word is dropped or duplicated.

Reset
REQ-026 SHALL: while SoftReset=1, state=IDLE, topA_write=0, msg_in_pop=0, busy=0, topA_address=0, topA_writedata=0, wr_count=0, and the pending register is cleared.
REQ-027 SHALL: reset asserted in REQ abandons the in-flight beat; the word is lost, not replayed, and wr_count is not incremented.

Structure
REQ-028 SHALL: package avalon_wr_pkg holds AVL_ADDR_W=17, AVL_DATA_W=521, and the state enum type wr_state_t {IDLE, REQ}.
REQ-029 SHALL: the block is implemented as one module with no sub-modules; the source FIFO is external.

Verification
REQ-030 SHALL: reset, then pulse setWr_addr_write=0x00100, then push 3 words A,B,C with waitrequest=0 -> writes at 0x100/0x101/0x102 on consecutive cycles, exactly 3 pops, wr_count=3, busy low afterwards.
REQ-031 SHALL: one word at base 0x00010 with waitrequest held high 5 cycles -> address and data stable for 6 cycles with topA_write=1, a single accept, no extra pop.
REQ-032 SHALL: base 0x1FFFF with 2 words -> writes at 0x1FFFF then 0x00000.
REQ-033 SHALL: setWr_addr_write=0x00400 pulsed while beat 1 (0x020) is stalled -> next beat goes to 0x00400, following beat to 0x00401.
REQ-034 SHALL: SoftReset asserted mid-stall, asynchronously between edges -> topA_write falls immediately, wr_count=0, FIFO contents untouched; after release, the next word goes to address 0x00000.
